// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared constants and types for the FIR coefficient path. Imported by
//   fir_coeff_loader, fir_cksum, fir_transpose and the benches.
//   COEFF_W : coefficient width (must match fir_transpose)
//   ADDR_W  : coefficient memory address width
//   SUM_W   : width of the load/readback checksums
package fir_pkg;

  localparam int unsigned COEFF_W = 12;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned SUM_W   = 16;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_VERIFY,
    LD_CHECK,
    LD_DONE
  } loader_state_t;

endpackage

// File: rtl/fir_cksum.sv
// fir_cksum
//   SUM_W-bit running sum of zero-extended DATA_W-bit words, modulo 2^SUM_W.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_i  : synchronous active-high reset, clears the sum
//     clr_i  : synchronous clear (wins over add_i)
//     add_i  : add data_i into the sum on this edge
//     data_i : word to accumulate
//     sum_o  : current sum
module fir_cksum #(
  parameter int unsigned DATA_W = fir_pkg::COEFF_W,
  parameter int unsigned SUM_W  = fir_pkg::SUM_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SUM_W-1:0]  sum_o
);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + SUM_W'(data_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Loads N coefficients from a valid/ready stream into the fir_transpose
//   coefficient memory at addresses 0..N-1, holding the filter in reset
//   (fir_hlt) for the whole load and releasing it when the load completes.
//
//   Build option FIR_COEFF_VERIFY_EN: when defined, a readback pass re-reads
//   addresses 0..N-1 and compares the sum of the read data against the sum
//   of the written data, reporting a mismatch on `error`. When undefined,
//   `error` and `read_address` are tied to 0 and `read_value` is unused.
//
//   Ports:
//     Clk           : clock, all state updates on the rising edge
//     Hlt           : synchronous active-high reset
//     start         : one-cycle load request, honoured only in IDLE
//     num_taps      : coefficient count N (sampled with start; 0 is ignored)
//     s_valid/s_data/s_ready : coefficient stream
//     write_address/write_value/load : registered write port to the FIR
//     read_address/read_value : readback port (read data one cycle later)
//     fir_hlt       : FIR reset, high from load start until DONE
//     busy          : load or verify in progress
//     done          : level, last load completed
//     error         : level, last verify mismatched
module fir_coeff_loader #(
  parameter int unsigned COEFF_W = fir_pkg::COEFF_W,
  parameter int unsigned ADDR_W  = fir_pkg::ADDR_W,
  parameter int unsigned SUM_W   = fir_pkg::SUM_W
) (
  input  logic               Clk,
  input  logic               Hlt,
  input  logic               start,
  input  logic [ADDR_W-1:0]  num_taps,
  input  logic               s_valid,
  input  logic [COEFF_W-1:0] s_data,
  output logic               s_ready,
  output logic [ADDR_W-1:0]  write_address,
  output logic [COEFF_W-1:0] write_value,
  output logic               load,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [COEFF_W-1:0] read_value,
  output logic               fir_hlt,
  output logic               busy,
  output logic               done,
  output logic               error
);

  import fir_pkg::*;

  loader_state_t state_q, state_d;

  logic [ADDR_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [COEFF_W-1:0] wr_val_q, wr_val_d;
  logic               load_q, load_d;
  logic               fir_hlt_q, fir_hlt_d;
  logic               done_q, done_d;

  logic               start_ok;
  logic               beat;

  // s_ready is gated by the beat count so it drops the cycle after the N-th
  // beat, while the state lingers one more cycle in LOAD so that DONE (and
  // the fir_hlt release) follows the last FIR write edge.
  assign s_ready  = (state_q == LD_LOAD) && (idx_q != n_q);
  assign beat     = s_ready && s_valid;
  assign start_ok = (state_q == LD_IDLE) && start && (num_taps != '0);

`ifdef FIR_COEFF_VERIFY_EN
  logic [ADDR_W-1:0] vcnt_q, vcnt_d;
  logic              error_q, error_d;
  logic [SUM_W-1:0]  wsum;
  logic [SUM_W-1:0]  rsum;
  logic              radd;

  // Read data for the address issued at count j arrives at count j+1.
  assign radd = (state_q == LD_VERIFY) && (vcnt_q != '0);

  fir_cksum #(
    .DATA_W (COEFF_W),
    .SUM_W  (SUM_W)
  ) u_wsum (
    .clk_i  (Clk),
    .rst_i  (Hlt),
    .clr_i  (start_ok),
    .add_i  (beat),
    .data_i (s_data),
    .sum_o  (wsum)
  );

  fir_cksum #(
    .DATA_W (COEFF_W),
    .SUM_W  (SUM_W)
  ) u_rsum (
    .clk_i  (Clk),
    .rst_i  (Hlt),
    .clr_i  (start_ok),
    .add_i  (radd),
    .data_i (read_value),
    .sum_o  (rsum)
  );

  assign read_address = ((state_q == LD_VERIFY) && (vcnt_q != n_q)) ? vcnt_q : '0;
  assign error        = error_q;
`else
  logic unused_read_value;
  assign unused_read_value = ^read_value;
  assign read_address      = '0;
  assign error             = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    wr_val_d  = wr_val_q;
    load_d    = 1'b0;
    fir_hlt_d = fir_hlt_q;
    done_d    = done_q;
`ifdef FIR_COEFF_VERIFY_EN
    vcnt_d    = vcnt_q;
    error_d   = error_q;
`endif

    case (state_q)
      LD_IDLE: begin
        if (start_ok) begin
          n_d       = num_taps;
          idx_d     = '0;
          done_d    = 1'b0;
          fir_hlt_d = 1'b1;
`ifdef FIR_COEFF_VERIFY_EN
          error_d   = 1'b0;
`endif
          state_d   = LD_LOAD;
        end
      end

      LD_LOAD: begin
        if (beat) begin
          wr_addr_d = idx_q;
          wr_val_d  = s_data;
          load_d    = 1'b1;
          idx_d     = idx_q + ADDR_W'(1);
        end else if (idx_q == n_q) begin
`ifdef FIR_COEFF_VERIFY_EN
          vcnt_d    = '0;
          state_d   = LD_VERIFY;
`else
          done_d    = 1'b1;
          fir_hlt_d = 1'b0;
          state_d   = LD_DONE;
`endif
        end
      end

`ifdef FIR_COEFF_VERIFY_EN
      // N address cycles plus one trailing cycle to absorb the last read.
      LD_VERIFY: begin
        if (vcnt_q == n_q) begin
          state_d = LD_CHECK;
        end else begin
          vcnt_d  = vcnt_q + ADDR_W'(1);
        end
      end

      LD_CHECK: begin
        error_d   = (rsum != wsum);
        done_d    = 1'b1;
        fir_hlt_d = 1'b0;
        state_d   = LD_DONE;
      end
`endif

      LD_DONE: begin
        state_d = LD_IDLE;
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Hlt) begin
      state_q   <= LD_IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_val_q  <= '0;
      load_q    <= 1'b0;
      fir_hlt_q <= 1'b1;
      done_q    <= 1'b0;
`ifdef FIR_COEFF_VERIFY_EN
      vcnt_q    <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_val_q  <= wr_val_d;
      load_q    <= load_d;
      fir_hlt_q <= fir_hlt_d;
      done_q    <= done_d;
`ifdef FIR_COEFF_VERIFY_EN
      vcnt_q    <= vcnt_d;
      error_q   <= error_d;
`endif
    end
  end

  assign write_address = wr_addr_q;
  assign write_value   = wr_val_q;
  assign load          = load_q;
  assign fir_hlt       = fir_hlt_q;
  assign done          = done_q;
  assign busy          = (state_q != LD_IDLE) && (state_q != LD_DONE);

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader
//   Directed and randomized bench for fir_coeff_loader. A behavioural FIR
//   coefficient memory (with optional single-address corruption) receives
//   the writes; expectations come from the coefficient list, the memory
//   contents and the documented latencies. Honours FIR_COEFF_VERIFY_EN.
module tb_fir_coeff_loader;

  import fir_pkg::*;

`ifdef FIR_COEFF_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic               Clk;
  logic               Hlt;
  logic               start;
  logic [ADDR_W-1:0]  num_taps;
  logic               s_valid;
  logic [COEFF_W-1:0] s_data;
  logic               s_ready;
  logic [ADDR_W-1:0]  write_address;
  logic [COEFF_W-1:0] write_value;
  logic               load;
  logic [ADDR_W-1:0]  read_address;
  logic [COEFF_W-1:0] read_value;
  logic               fir_hlt;
  logic               busy;
  logic               done;
  logic               error;

  fir_coeff_loader #(
    .COEFF_W (COEFF_W),
    .ADDR_W  (ADDR_W),
    .SUM_W   (SUM_W)
  ) dut (
    .Clk           (Clk),
    .Hlt           (Hlt),
    .start         (start),
    .num_taps      (num_taps),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .write_address (write_address),
    .write_value   (write_value),
    .load          (load),
    .read_address  (read_address),
    .read_value    (read_value),
    .fir_hlt       (fir_hlt),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  logic [COEFF_W-1:0] coef [0:255];
  logic [COEFF_W-1:0] mem  [0:255];
  logic               corrupt_en   = 1'b0;
  logic [ADDR_W-1:0]  corrupt_addr = '0;
  logic [COEFF_W-1:0] corrupt_val  = '0;

  typedef struct {
    int a;
    int v;
  } wr_t;
  wr_t wq[$];

  // FIR coefficient memory: writes on the edge where load is high, read
  // data one cycle after the address.
  always @(posedge Clk) begin
    if (load === 1'b1) begin
      mem[write_address] <= (corrupt_en && write_address == corrupt_addr) ? corrupt_val : write_value;
      wq.push_back('{a: int'(write_address), v: int'(write_value)});
    end
    read_value <= mem[read_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    edges++;
    #1;
  endtask

  // Start a load of n coefficients from coef[], with gap_min..gap_max idle
  // cycles before each beat after the first. poke holds start high (with a
  // different num_taps) during the beats; it must be ignored.
  task automatic run_load(input int n, input int gap_min, input int gap_max, input bit poke);
    int t0;
    int last;
    int guard;
    int sum_w;
    int sum_r;
    int exp_edge;
    bit exp_err;
    wq.delete();
    start    = 1'b1;
    num_taps = 8'(n);
    tick();
    t0       = edges;
    start    = poke;
    num_taps = 8'd9;
    check("ready_after_start", s_ready, 1);
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("error_cleared", error, 0);
    check("hlt_in_load", fir_hlt, 1);
    last = t0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (i == 0) ? 0 : int'($urandom_range(gap_max, gap_min));
      s_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        tick();
        check("no_load_in_gap", load, 0);
      end
      s_valid = 1'b1;
      s_data  = coef[i];
      guard   = 0;
      while (s_ready !== 1'b1 && guard < 8) begin
        tick();
        guard++;
      end
      check("ready_for_beat", s_ready, 1);
      tick();
      last = edges;
      check("load_pulse", load, 1);
      check("write_address", write_address, 32'(i));
      check("write_value", write_value, 32'(coef[i]));
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check("ready_drops", s_ready, 0);

    guard = 0;
    while (done !== 1'b1 && guard < 4 * n + 20) begin
      tick();
      guard++;
    end
    check("done_seen", done, 1);
    // done is visible during cycle T+N+2 (T+2N+4 with readback) for a
    // continuous stream, i.e. after edge T+N+1 / T+2N+3.
    exp_edge = ((gap_max == 0) ? t0 + n : last) + 1 + (VERIFY ? n + 2 : 0);
    check("done_edge", 32'(edges), 32'(exp_edge));
    check("hlt_released", fir_hlt, 0);
    check("busy_at_done", busy, 0);

    sum_w = 0;
    sum_r = 0;
    for (int i = 0; i < n; i++) begin
      sum_w += int'(coef[i]);
      sum_r += int'(mem[i]);
    end
    exp_err = VERIFY && ((sum_w & 16'hFFFF) != (sum_r & 16'hFFFF));
    check("error_at_done", error, 32'(exp_err));

    check("write_count", wq.size(), n);
    for (int i = 0; i < wq.size() && i < n; i++) begin
      check("fir_addr", wq[i].a, i);
      check("fir_value", wq[i].v, int'(coef[i]));
    end

    tick();
    check("done_holds", done, 1);
    check("error_holds", error, 32'(exp_err));
    check("idle_not_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Hlt      = 1'b1;
    start    = 1'b0;
    num_taps = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    #1;
    repeat (3) tick();
    check("rst_fir_hlt", fir_hlt, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_load", load, 0);
    check("rst_busy", busy, 0);
    check("rst_write_address", write_address, 0);
    check("rst_read_address", read_address, 0);
    Hlt = 1'b0;
    tick();
    check("idle_s_ready", s_ready, 0);

    // N=4 continuous, 10,20,30,40
    coef[0] = 12'd10; coef[1] = 12'd20; coef[2] = 12'd30; coef[3] = 12'd40;
    run_load(4, 0, 0, 1'b0);

    // Same load, FIR corrupts address 2 to 31 (read sum 101 vs 100)
    corrupt_en   = 1'b1;
    corrupt_addr = 8'd2;
    corrupt_val  = 12'd31;
    run_load(4, 0, 0, 1'b0);
    corrupt_en   = 1'b0;

    // N=3 with two idle cycles between beats
    for (int i = 0; i < 3; i++) coef[i] = 12'($urandom);
    run_load(3, 2, 2, 1'b0);

    // Reset mid-load after 2 beats
    start    = 1'b1;
    num_taps = 8'd5;
    tick();
    start    = 1'b0;
    s_valid  = 1'b1;
    s_data   = 12'h5A5;
    tick();
    tick();
    check("beat2_loaded", load, 1);
    Hlt = 1'b1;
    tick();
    Hlt = 1'b0;
    check("hlt_fir_hlt", fir_hlt, 1);
    check("hlt_s_ready", s_ready, 0);
    check("hlt_busy", busy, 0);
    check("hlt_done", done, 0);
    check("hlt_load", load, 0);
    check("hlt_write_address", write_address, 0);
    tick();
    check("hlt_no_beat", load, 0);
    s_valid = 1'b0;

    // start with N=0 ignored
    start    = 1'b1;
    num_taps = 8'd0;
    tick();
    start    = 1'b0;
    check("n0_busy", busy, 0);
    check("n0_s_ready", s_ready, 0);

    // Clean restart with N=2, start pulses while busy ignored
    coef[0] = 12'hABC; coef[1] = 12'h123;
    run_load(2, 0, 0, 1'b1);

    // Randomized loads, some with a corrupted FIR word
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(24, 1));
      for (int i = 0; i < n; i++) coef[i] = 12'($urandom);
      corrupt_en   = ($urandom_range(1, 0) == 1);
      corrupt_addr = 8'($urandom_range(n - 1, 0));
      corrupt_val  = 12'($urandom);
      run_load(n, 0, (r % 2 == 0) ? 0 : 3, 1'b0);
    end
    corrupt_en = 1'b0;

    // Largest load: highest address 254
    for (int i = 0; i < 255; i++) coef[i] = 12'($urandom);
    run_load(255, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
